alu_op_sequencer: RTL and testbench

// - Upstream control stage for the 4-bit ALU (A[3:0], B[3:0], S[1:0] -> Y[7:0]).
// - Collects A, B and S one after another from a shared 4-bit switch bus, using a one-cycle load strobe.
// - Holds the operands stable on the ALU inputs, waits for the combinational result to settle,

---
 rtl/alu_op_sequencer.sv | 100 ++++++++++
 tb/tb_alu_op_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Operand/select collector for the 4-bit ALU: loads A, B, S from the switch bus,
// holds them for EXEC_CYCLES while the ALU settles, then registers the result.
module alu_op_sequencer #(
  parameter int OP_W        = 4,
  parameter int SEL_W       = 2,
  parameter int Y_W         = 8,
  parameter int EXEC_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  sw_data,
  input  logic             load,
  input  logic             clr,
  output logic [OP_W-1:0]  alu_a,
  output logic [OP_W-1:0]  alu_b,
  output logic [SEL_W-1:0] alu_s,
  input  logic [Y_W-1:0]   alu_y,
  output logic [Y_W-1:0]   result,
  output logic             result_valid,
  output logic             busy,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] op_count
);

  localparam int SW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [SW-1:0] LAST = SW'(EXEC_CYCLES - 1);

  typedef enum logic [2:0] {
    GET_A = 3'd0,
    GET_B = 3'd1,
    GET_S = 3'd2,
    EXEC  = 3'd3,
    SHOW  = 3'd4
  } state_t;

  state_t       st;
  logic [SW-1:0] settle;

  assign state = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= GET_A;
      settle       <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_s        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      op_count     <= '0;
    end else if (clr) begin
      // abort keeps operands, result and count for the display
      st           <= GET_A;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (st)
        GET_A: if (load) begin
          alu_a <= sw_data;
          st    <= GET_B;
        end
        GET_B: if (load) begin
          alu_b <= sw_data;
          st    <= GET_S;
        end
        GET_S: if (load) begin
          alu_s  <= sw_data[SEL_W-1:0];
          settle <= '0;
          busy   <= 1'b1;
          st     <= EXEC;
        end
        EXEC: begin
          // load is deliberately not looked at while the ALU settles
          if (settle == LAST) begin
            result       <= alu_y;
            result_valid <= 1'b1;
            op_count     <= op_count + CNT_W'(1);
            busy         <= 1'b0;
            st           <= SHOW;
          end else begin
            settle <= settle + SW'(1);
          end
        end
        SHOW: if (load) begin
          alu_a        <= sw_data;
          result_valid <= 1'b0;
          st           <= GET_B;
        end
        default: begin
          st           <= GET_A;
          result_valid <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized scoreboard bench: two sequencers (8-bit and 2-bit op counters) share
// one stimulus stream; each drives an ALU stub with Y = {A,B}.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst, load, clr;
  logic [3:0] sw_data;

  logic [3:0] alu_a, alu_b, a2, b2;
  logic [1:0] alu_s, s2;
  logic [7:0] alu_y, y2, result, result2;
  logic       rv, rv2, busy, busy2;
  logic [2:0] state, state2;
  logic [7:0] op_count;
  logic [1:0] op_count2;

  assign alu_y = {alu_a, alu_b};
  assign y2    = {a2, b2};

  alu_op_sequencer #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .sw_data(sw_data), .load(load), .clr(clr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_y(alu_y),
    .result(result), .result_valid(rv), .busy(busy), .state(state),
    .op_count(op_count)
  );

  alu_op_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .sw_data(sw_data), .load(load), .clr(clr),
    .alu_a(a2), .alu_b(b2), .alu_s(s2), .alu_y(y2),
    .result(result2), .result_valid(rv2), .busy(busy2), .state(state2),
    .op_count(op_count2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] y;
    int         cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference: operation results and completed-op total
  int         m_cnt = 0;
  logic [7:0] m_res = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every rising result_valid must match the oldest issued operation
  logic rv_prev = 1'b0;
  always @(negedge clk) begin
    if (rv && !rv_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(result), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result",    32'(result),    32'(e.y));
        chk("result2",   32'(result2),   32'(e.y));
        chk("op_count",  32'(op_count),  32'(e.cnt % 256));
        chk("op_count2", 32'(op_count2), 32'(e.cnt % 4));
        chk("rv2",       32'(rv2),       32'd1);
      end
    end
    rv_prev <= rv;
  end

  task automatic pulse(input logic [3:0] v);
    sw_data = v;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
    sw_data = 4'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mode: 0 normal, 1 stray load in EXEC, 2 clr in last EXEC cycle, 3 rst in EXEC
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s,
                        input int mode, input int gap);
    pulse(a);
    chk("state_after_a", 32'(state), 32'd1);
    chk("rv_after_a",    32'(rv),    32'd0);
    chk("alu_a",         32'(alu_a), 32'(a));
    idle(gap);
    pulse(b);
    chk("state_after_b", 32'(state), 32'd2);
    chk("alu_b",         32'(alu_b), 32'(b));
    idle(gap);
    if (mode < 2) begin
      m_cnt++;
      m_res = {a, b};
      exp_q.push_back('{y: {a, b}, cnt: m_cnt});
    end
    pulse({2'($urandom), s});
    chk("alu_s",      32'(alu_s), 32'(s));
    chk("state_exec", 32'(state), 32'd3);
    chk("busy_exec",  32'(busy),  32'd1);
    case (mode)
      0, 1: begin
        if (mode == 1) begin
          sw_data = 4'hF;
          load    = 1'b1;
        end
        @(negedge clk);
        load = 1'b0;
        chk("rv_early", 32'(rv), 32'd0);
        @(negedge clk);
        chk("rv_latency", 32'(rv),    32'd1);
        chk("state_show", 32'(state), 32'd4);
        chk("busy_show",  32'(busy),  32'd0);
        chk("ops_held",   32'({alu_a, alu_b, alu_s}), 32'({a, b, s}));
        idle(gap);
        chk("show_hold", 32'({state, rv, result}), 32'({3'd4, 1'b1, m_res}));
      end
      2: begin
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_state",  32'(state),    32'd0);
        chk("clr_rv",     32'(rv),       32'd0);
        chk("clr_busy",   32'(busy),     32'd0);
        chk("clr_result", 32'(result),   32'(m_res));
        chk("clr_count",  32'(op_count), 32'(m_cnt % 256));
        chk("clr_count2", 32'(op_count2), 32'(m_cnt % 4));
      end
      default: begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_cnt = 0;
        m_res = 8'h00;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ops",   32'({alu_a, alu_b, alu_s}), 32'd0);
        chk("rst_res",   32'({result, rv, busy}), 32'd0);
        chk("rst_count", 32'({op_count, op_count2}), 32'd0);
      end
    endcase
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; clr = 1'b0; sw_data = 4'h0;
    idle(2);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_ops",   32'({alu_a, alu_b, alu_s}), 32'd0);
    chk("reset_res",   32'({result, rv, busy}), 32'd0);
    chk("reset_count", 32'({op_count, op_count2}), 32'd0);
    rst = 1'b0;
    idle(3);
    chk("idle_hold", 32'(state), 32'd0);

    run_op(4'h3, 4'h5, 2'd2, 0, 0);   // basic op -> 35, count 1
    run_op(4'h9, 4'h1, 2'd0, 1, 0);   // chained from SHOW, stray F load -> 91
    run_op(4'h7, 4'h2, 2'd1, 2, 1);   // clr collides with capture
    run_op(4'hA, 4'hB, 2'd3, 0, 2);
    run_op(4'h6, 4'hC, 2'd2, 3, 0);   // rst mid-EXEC
    run_op(4'h4, 4'hE, 2'd1, 0, 1);   // full op after reset
    for (int i = 0; i < 5; i++)       // 2-bit counter: 2,3,0,1,2
      run_op(4'($urandom), 4'($urandom), 2'($urandom), 0, 0);

    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 9);
      run_op(4'($urandom), 4'($urandom), 2'($urandom),
             (r < 6) ? 0 : (r < 8) ? 1 : (r < 9) ? 2 : 3, $urandom_range(0, 3));
    end

    idle(3);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
